// File: rtl/mul_div_pkg.sv
// Shared encodings for the RV32M multiply/divide unit: FUNC3 opcodes, FSM states, iteration count.
package mul_div_pkg;

   localparam logic [2:0] F3_MUL    = 3'd0;
   localparam logic [2:0] F3_MULH   = 3'd1;
   localparam logic [2:0] F3_MULHSU = 3'd2;
   localparam logic [2:0] F3_MULHU  = 3'd3;
   localparam logic [2:0] F3_DIV    = 3'd4;
   localparam logic [2:0] F3_DIVU   = 3'd5;
   localparam logic [2:0] F3_REM    = 3'd6;
   localparam logic [2:0] F3_REMU   = 3'd7;

   localparam int ITER_COUNT = 32;
   localparam int CNT_W      = 6;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   function automatic logic a_is_signed(input logic [2:0] f3);
      return (f3 == F3_MULH) || (f3 == F3_MULHSU) || (f3 == F3_DIV) || (f3 == F3_REM);
   endfunction

   function automatic logic b_is_signed(input logic [2:0] f3);
      return (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
   endfunction

endpackage

// File: rtl/mul_div_core.sv
// Unsigned radix-2 iterative datapath: shift-add multiply or restoring divide, one step per cycle.
module mul_div_core
   import mul_div_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            i_clk,
   input  logic            i_rst_n,
   input  logic            i_load,
   input  logic            i_step,
   input  logic            i_is_div,
   input  logic [XLEN-1:0] i_a,
   input  logic [XLEN-1:0] i_b,
   output logic [XLEN-1:0] o_hi,
   output logic [XLEN-1:0] o_lo
);

   logic [XLEN-1:0] r_hi;
   logic [XLEN-1:0] r_lo;
   logic [XLEN-1:0] r_b;
   logic            r_div;

   logic [XLEN:0]   w_add;
   logic [XLEN:0]   w_shift;
   logic            w_ge;
   logic [XLEN-1:0] w_sub;

   // Multiply: hi accumulates, lo holds the multiplier and collects product bits shifted out of hi.
   assign w_add   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);
   // Divide: hi is the partial remainder, lo shifts the dividend out and quotient bits in.
   assign w_shift = {r_hi, r_lo[XLEN-1]};
   assign w_ge    = (w_shift >= {1'b0, r_b});
   assign w_sub   = w_shift[XLEN-1:0] - r_b;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_hi  <= '0;
         r_lo  <= '0;
         r_b   <= '0;
         r_div <= 1'b0;
      end else if (i_load) begin
         r_hi  <= '0;
         r_lo  <= i_a;
         r_b   <= i_b;
         r_div <= i_is_div;
      end else if (i_step) begin
         if (r_div) begin
            r_hi <= w_ge ? w_sub : w_shift[XLEN-1:0];
            r_lo <= {r_lo[XLEN-2:0], w_ge};
         end else begin
            r_hi <= w_add[XLEN:1];
            r_lo <= {w_add[0], r_lo[XLEN-1:1]};
         end
      end
   end

   assign o_hi = r_hi;
   assign o_lo = r_lo;

endmodule

// File: rtl/mul_div_unit.sv
// RV32M multiply/divide unit: accepts a request, iterates 32 cycles in mul_div_core, presents a one-cycle result.
module mul_div_unit
   import mul_div_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            CLK,
   input  logic            RST,
   input  logic            START,
   input  logic [2:0]      FUNC3,
   input  logic [XLEN-1:0] OPERAND_A,
   input  logic [XLEN-1:0] OPERAND_B,
   input  logic            FLUSH,
   output logic            BUSY,
   output logic            RESULT_VALID,
   output logic [XLEN-1:0] RESULT
);

   function automatic logic [XLEN-1:0] cond_neg(input logic en, input logic [XLEN-1:0] v);
      return en ? -v : v;
   endfunction

   state_t             r_state;
   state_t             w_next;
   logic [CNT_W-1:0]   r_cnt;
   logic [2:0]         r_func3;
   logic               r_negate;
   logic               r_special;
   logic [XLEN-1:0]    r_spec_val;

   logic               w_accept;
   logic               w_is_div;
   logic               w_a_neg;
   logic               w_b_neg;
   logic [XLEN-1:0]    w_mag_a;
   logic [XLEN-1:0]    w_mag_b;
   logic               w_div_zero;
   logic               w_ovf;
   logic               w_special;
   logic [XLEN-1:0]    w_spec_val;
   logic               w_negate;
   logic [XLEN-1:0]    w_core_hi;
   logic [XLEN-1:0]    w_core_lo;
   logic [2*XLEN-1:0]  w_prod;
   logic [XLEN-1:0]    w_mul_res;
   logic [XLEN-1:0]    w_div_res;

   assign w_accept   = (r_state == ST_IDLE) && START && !FLUSH;
   assign w_is_div   = FUNC3[2];
   assign w_a_neg    = a_is_signed(FUNC3) && OPERAND_A[XLEN-1];
   assign w_b_neg    = b_is_signed(FUNC3) && OPERAND_B[XLEN-1];
   assign w_mag_a    = cond_neg(w_a_neg, OPERAND_A);
   assign w_mag_b    = cond_neg(w_b_neg, OPERAND_B);
   assign w_div_zero = w_is_div && (OPERAND_B == '0);
   assign w_ovf      = ((FUNC3 == F3_DIV) || (FUNC3 == F3_REM)) &&
                       (OPERAND_A == {1'b1, {(XLEN-1){1'b0}}}) && (OPERAND_B == '1);
   assign w_special  = w_div_zero || w_ovf;
   // Remainder follows the dividend's sign; quotient and product follow the XOR of both signs.
   assign w_negate   = (w_is_div && FUNC3[1]) ? w_a_neg : (w_a_neg ^ w_b_neg);

   always_comb begin
      w_spec_val = '0;
      if (w_div_zero)
         w_spec_val = FUNC3[1] ? OPERAND_A : '1;
      else if (!FUNC3[1])
         w_spec_val = {1'b1, {(XLEN-1){1'b0}}};
   end

   always_comb begin
      w_next = r_state;
      if (FLUSH) begin
         w_next = ST_IDLE;
      end else begin
         case (r_state)
            ST_IDLE: if (START) w_next = w_special ? ST_DONE : ST_BUSY;
            ST_BUSY: if (r_cnt == CNT_W'(ITER_COUNT - 1)) w_next = ST_DONE;
            ST_DONE: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_state    <= ST_IDLE;
         r_cnt      <= '0;
         r_func3    <= '0;
         r_negate   <= 1'b0;
         r_special  <= 1'b0;
         r_spec_val <= '0;
      end else begin
         r_state <= w_next;
         if (FLUSH || w_accept)
            r_cnt <= '0;
         else if (r_state == ST_BUSY)
            r_cnt <= r_cnt + 1'b1;
         if (w_accept) begin
            r_func3    <= FUNC3;
            r_negate   <= w_negate;
            r_special  <= w_special;
            r_spec_val <= w_spec_val;
         end
      end
   end

   mul_div_core #(
      .XLEN(XLEN)
   ) u_core (
      .i_clk   (CLK),
      .i_rst_n (RST),
      .i_load  (w_accept),
      .i_step  ((r_state == ST_BUSY) && !FLUSH),
      .i_is_div(w_is_div),
      .i_a     (w_mag_a),
      .i_b     (w_mag_b),
      .o_hi    (w_core_hi),
      .o_lo    (w_core_lo)
   );

   // The last iteration lands on the edge entering DONE, so the result is formed combinationally there.
   assign w_prod    = r_negate ? -{w_core_hi, w_core_lo} : {w_core_hi, w_core_lo};
   assign w_mul_res = (r_func3 == F3_MUL) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];
   assign w_div_res = r_func3[1] ? cond_neg(r_negate, w_core_hi) : cond_neg(r_negate, w_core_lo);

   assign RESULT_VALID = (r_state == ST_DONE);
   assign RESULT       = !RESULT_VALID ? '0 :
                         r_special     ? r_spec_val :
                         r_func3[2]    ? w_div_res : w_mul_res;
   assign BUSY         = RST && (w_accept || (r_state == ST_BUSY));

endmodule
